// File: rtl/tc_queue_pkg.sv
// Shared defaults for the tc_queue FIFO: word width, pointer width and depth.
package tc_queue_pkg;

    localparam int TC_DATA_W = 8;
    localparam int TC_ADDR_W = 8;

    function automatic int tc_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/tc_queue_ram.sv
// DEPTH x DATA_W simple dual-port RAM with a registered, resettable read port.
module tc_queue_ram
    import tc_queue_pkg::*;
#(
    parameter int DATA_W = TC_DATA_W,
    parameter int ADDR_W = TC_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = tc_depth(ADDR_W);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) r_mem[waddr] <= wdata;
    end

    // Same-address read during write sees the old word.
    always_ff @(posedge clk) begin
        if (rst)     r_rdata <= '0;
        else if (re) r_rdata <= r_mem[raddr];
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/tc_queue.sv
// FIFO queue: pointers, explicit count, accept logic and sticky error flags.
module tc_queue
    import tc_queue_pkg::*;
#(
    parameter int DATA_W = TC_DATA_W,
    parameter int ADDR_W = TC_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] out,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_ovf;
    logic              r_unf;

    logic w_empty;
    logic w_full;
    logic w_push_ok;
    logic w_pop_ok;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);
    // A pop frees the head slot, so a full queue still takes a push.
    assign w_push_ok = push && (!w_full || pop);
    assign w_pop_ok  = pop && !w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (push && w_full && !pop) r_ovf <= 1'b1;
            if (pop && w_empty)         r_unf <= 1'b1;
        end
    end

    tc_queue_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (w_push_ok && !rst),
        .waddr (r_wr_ptr),
        .wdata (in),
        .re    (w_pop_ok && !rst),
        .raddr (r_rd_ptr),
        .rdata (out)
    );

    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = r_count;
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule

// File: tb/tb_tc_queue.sv
// Bench for tc_queue: queue-based reference model plus directed literal checks.
module tb_tc_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] in = 8'h00;
    logic [7:0] out;
    logic       empty;
    logic       full;
    logic [8:0] count;
    logic       overflow;
    logic       underflow;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] q[$];
    logic [7:0] m_out = 8'h00;
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;
    bit         m_valid = 1'b0;

    always #5 clk = ~clk;

    tc_queue dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .in        (in),
        .out       (out),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a plain queue updated from the rules, checked 1ns after each edge.
    always @(posedge clk) begin : model
        int sz;
        sz = q.size();
        if (rst) begin
            q.delete();
            m_out   = 8'h00;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_valid = 1'b1;
        end else begin
            if (push && sz == 256 && !pop) m_ovf = 1'b1;
            if (pop && sz == 0)            m_unf = 1'b1;
            if (pop && sz > 0)             m_out = q.pop_front();
            if (push && (sz < 256 || pop)) q.push_back(in);
        end
        #1;
        if (m_valid) begin
            chk("m_out",       out,       m_out);
            chk("m_count",     count,     q.size());
            chk("m_empty",     empty,     q.size() == 0);
            chk("m_full",      full,      q.size() == 256);
            chk("m_overflow",  overflow,  m_ovf);
            chk("m_underflow", underflow, m_unf);
        end
    end

    task automatic step(input logic r, input logic p, input logic o,
                        input logic [7:0] d);
        @(negedge clk);
        rst  = r;
        push = p;
        pop  = o;
        in   = d;
        @(posedge clk);
        #2;
        rst  = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic fill256();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'(i);
            step(1'b0, 1'b1, 1'b0, v);
        end
    endtask

    initial begin
        // 1: basic ordering
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("t1_rst_count", count, 0);
        chk("t1_rst_empty", empty, 1);
        step(1'b0, 1'b1, 1'b0, 8'h11);
        step(1'b0, 1'b1, 1'b0, 8'h22);
        step(1'b0, 1'b1, 1'b0, 8'h33);
        chk("t1_count3", count, 3);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t1_pop0", out, 8'h11);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t1_pop1", out, 8'h22);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t1_pop2", out, 8'h33);
        chk("t1_count0", count, 0);
        chk("t1_empty", empty, 1);

        // 2: fill, overflow, drain
        step(1'b1, 1'b0, 1'b0, 8'h00);
        fill256();
        step(1'b0, 1'b1, 1'b0, 8'hFF);
        chk("t2_full", full, 1);
        chk("t2_count", count, 256);
        chk("t2_ovf", overflow, 1);
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            chk("t2_drain", out, i);
        end
        chk("t2_count0", count, 0);
        chk("t2_ovf_sticky", overflow, 1);

        // 3: underflow on empty
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t3_out", out, 8'h00);
        chk("t3_unf", underflow, 1);
        chk("t3_count", count, 0);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t3_unf2", underflow, 1);

        // 4: push+pop while full
        step(1'b1, 1'b0, 1'b0, 8'h00);
        fill256();
        step(1'b0, 1'b1, 1'b1, 8'hAB);
        chk("t4_out", out, 8'h00);
        chk("t4_count", count, 256);
        chk("t4_ovf", overflow, 0);
        for (int i = 1; i < 256; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            chk("t4_drain", out, i);
        end
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t4_ab", out, 8'hAB);
        chk("t4_count0", count, 0);

        // 5: push+pop while empty, no bypass
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'h5A);
        chk("t5_unf", underflow, 1);
        chk("t5_count", count, 1);
        chk("t5_out", out, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t5_pop", out, 8'h5A);

        // 6: reset mid-stream wins over push
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 6; i++) begin
            logic [7:0] v;
            v = 8'(i);
            step(1'b0, 1'b1, 1'b0, v);
        end
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t6_pre_count", count, 5);
        chk("t6_pre_out", out, 8'h01);
        step(1'b1, 1'b1, 1'b0, 8'h99);
        chk("t6_count", count, 0);
        chk("t6_empty", empty, 1);
        chk("t6_out", out, 8'h00);
        chk("t6_flags", {overflow, underflow}, 2'b00);
        step(1'b0, 1'b1, 1'b0, 8'h77);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t6_pop", out, 8'h77);

        // Pointer wrap: 300 simultaneous push/pop pairs
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 1; i <= 300; i++) begin
            logic [7:0] v;
            v = 8'(i);
            step(1'b0, 1'b1, 1'b1, v);
            chk("wrap_out", out, (i - 1) & 8'hFF);
        end
        chk("wrap_count", count, 1);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
